// File: rtl/mant_div_iter_if.sv
// Start/done handshake and operand/result bundle for the iterative mantissa divider.
interface mant_div_iter_if #(
  parameter int WID = 26
);
  logic           start;
  logic [WID-1:0] num;
  logic [WID-1:0] den;
  logic           busy;
  logic           done;
  logic [WID-1:0] quot;
  logic           sticky;
  logic           err;

  modport master (
    output start, num, den,
    input  busy, done, quot, sticky, err
  );

  modport slave (
    input  start, num, den,
    output busy, done, quot, sticky, err
  );
endinterface

// File: rtl/mant_div_iter.sv
// Iterative restoring fraction divider: quot = floor(num*2^WID/den), sticky = remainder != 0.
// Define MANT_DIV_RADIX4_EN to retire two quotient bits per clock instead of one.
//
// state | meaning
// IDLE  | waiting for start
// ERR   | invalid operands accepted; error result loads on the next edge
// RUN   | restoring iterations, cnt counts down to the last one
// DONE  | one-cycle result strobe; a new start is accepted here too
module mant_div_iter #(
  parameter int WID = 26,
  parameter int CW  = 5
) (
  input  logic          clk,
  input  logic          rst,
  mant_div_iter_if.slave dv
);

  if ((1 << CW) < WID) begin : g_cw_chk
    $error("mant_div_iter: CW too small for WID");
  end

`ifdef MANT_DIV_RADIX4_EN
  if ((WID % 2) != 0) begin : g_even_chk
    $error("mant_div_iter: radix-4 needs an even WID");
  end
  localparam logic [CW-1:0] CNT_INIT = CW'(WID / 2 - 1);
`else
  localparam logic [CW-1:0] CNT_INIT = CW'(WID - 1);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ERR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state, state_nxt;
  logic [WID:0]   rem, rem_nxt;
  logic [WID-1:0] dreg, dreg_nxt;
  logic [WID-1:0] q, q_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [WID-1:0] quot, quot_nxt;
  logic           sticky, sticky_nxt;
  logic           err, err_nxt;

  logic [WID:0]   r1, rem1, rem_step;
  logic [WID-1:0] q1, q_step;
  logic           ge1;
  logic           bad_op;

`ifdef MANT_DIV_RADIX4_EN
  logic [WID:0]   r2, rem2;
  logic [WID-1:0] q2;
  logic           ge2;
`endif

  // One restoring step: rem stays below dreg, so the shifted value fits in WID+1 bits.
  always_comb begin
    r1   = rem << 1;
    ge1  = (r1 >= {1'b0, dreg});
    rem1 = ge1 ? (r1 - {1'b0, dreg}) : r1;
    q1   = (q << 1) | {{(WID-1){1'b0}}, ge1};
`ifdef MANT_DIV_RADIX4_EN
    r2       = rem1 << 1;
    ge2      = (r2 >= {1'b0, dreg});
    rem2     = ge2 ? (r2 - {1'b0, dreg}) : r2;
    q2       = (q1 << 1) | {{(WID-1){1'b0}}, ge2};
    rem_step = rem2;
    q_step   = q2;
`else
    rem_step = rem1;
    q_step   = q1;
`endif
  end

  assign bad_op = (dv.den == '0) || (dv.num >= dv.den);

  always_comb begin
    state_nxt  = state;
    rem_nxt    = rem;
    dreg_nxt   = dreg;
    q_nxt      = q;
    cnt_nxt    = cnt;
    quot_nxt   = quot;
    sticky_nxt = sticky;
    err_nxt    = err;
    case (state)
      IDLE, DONE: begin
        if (dv.start) begin
          rem_nxt   = {1'b0, dv.num};
          dreg_nxt  = dv.den;
          q_nxt     = '0;
          cnt_nxt   = CNT_INIT;
          state_nxt = bad_op ? ERR : RUN;
        end else if (state == DONE) begin
          state_nxt = IDLE;
        end
      end
      ERR: begin
        quot_nxt   = '1;
        sticky_nxt = 1'b1;
        err_nxt    = 1'b1;
        state_nxt  = DONE;
      end
      RUN: begin
        rem_nxt = rem_step;
        q_nxt   = q_step;
        if (cnt == '0) begin
          quot_nxt   = q_step;
          sticky_nxt = (rem_step != '0);
          err_nxt    = 1'b0;
          state_nxt  = DONE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rem    <= '0;
      dreg   <= '0;
      q      <= '0;
      cnt    <= '0;
      quot   <= '0;
      sticky <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      rem    <= rem_nxt;
      dreg   <= dreg_nxt;
      q      <= q_nxt;
      cnt    <= cnt_nxt;
      quot   <= quot_nxt;
      sticky <= sticky_nxt;
      err    <= err_nxt;
    end
  end

  assign dv.busy   = (state == RUN);
  assign dv.done   = (state == DONE);
  assign dv.quot   = quot;
  assign dv.sticky = sticky;
  assign dv.err    = err;

endmodule
